exec_unit: RTL and testbench

Execute stage that consumes the two latched operands from the register file and returns a result to it over its write port. Performs single-cycle ALU operations and an optional 32-cycle iterative multiply. Maintains a 4-bit condition-flag register for the branch logic. Its outputs drive the register file's wr, drAddr and writeData directly.

---
 rtl/exec_pkg.sv | 33 +++
 rtl/exec_unit_mul_seq.sv | 69 ++++++
 rtl/exec_unit.sv | 172 +++++++++++++++++
 tb/tb_exec_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: opcodes, FSM encoding, flag bit positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exec_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        WB   = 2'b10
    } state_t;

    // Flag vector is {Z,N,C,V}
    localparam logic [1:0] FLAG_Z = 2'd3;
    localparam logic [1:0] FLAG_N = 2'd2;
    localparam logic [1:0] FLAG_C = 2'd1;
    localparam logic [1:0] FLAG_V = 2'd0;

    localparam int MUL_ITER = 32;

endpackage

// File: rtl/exec_unit_mul_seq.sv
// Shift-add multiplier, one multiplier bit per cycle LSB first, low 32 bits of product.
// Latency: start at edge N, done asserted during cycle N+32 with result valid alongside.
// Backpressure: none; start is only raised by the owner while the sequencer is idle.
module mul_seq
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [4:0] LAST_ITER = 5'(MUL_ITER - 1);

    logic        run_q, run_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] acc_nxt;

    // result is the post-iteration accumulator so the owner can latch it on the final edge
    assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    assign done    = run_q && (cnt_q == LAST_ITER);
    assign result  = acc_nxt;

    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            run_d    = 1'b1;
            cnt_d    = 5'd0;
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = 32'd0;
        end else if (run_q) begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == LAST_ITER) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q    <= 1'b0;
            cnt_q    <= 5'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus optional iterative MUL (enabled by EXEC_MUL_EN).
// Latency: ALU writeback strobed the cycle after acceptance; MUL strobed 33 cycles after.
// Backpressure: ready drops for the whole multiply; valid_in is ignored until it returns.
module exec_unit
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready,
    input  logic [3:0]  alu_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [3:0]  dest,
    output logic        wb_en,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic [3:0]  flags
);

    logic        accept_vld;
    logic [32:0] add_w;
    logic [31:0] sub_w;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic        alu_wr;
    logic        alu_upd;
    logic        alu_c;
    logic        alu_v;

    logic        wb_en_q, wb_en_d;
    logic [3:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [3:0]  flags_q, flags_d;

    assign accept_vld = valid_in && ready;
    assign add_w      = {1'b0, op_a} + {1'b0, op_b};
    assign sub_w      = op_a - op_b;
    assign shamt      = op_b[4:0];

    always_comb begin
        alu_res = 32'd0;
        alu_wr  = 1'b0;
        alu_upd = 1'b0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_res = add_w[31:0];
                alu_wr  = 1'b1;
                alu_upd = 1'b1;
                alu_c   = add_w[32];
                alu_v   = (op_a[31] == op_b[31]) && (add_w[31] != op_a[31]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_w;
                alu_wr  = (alu_op == OP_SUB);
                alu_upd = 1'b1;
                alu_c   = (op_a < op_b);
                alu_v   = (op_a[31] != op_b[31]) && (sub_w[31] != op_a[31]);
            end
            OP_AND: begin alu_res = op_a & op_b;             alu_wr = 1'b1; end
            OP_OR:  begin alu_res = op_a | op_b;             alu_wr = 1'b1; end
            OP_XOR: begin alu_res = op_a ^ op_b;             alu_wr = 1'b1; end
            OP_SLL: begin alu_res = op_a << shamt;           alu_wr = 1'b1; end
            OP_SRL: begin alu_res = op_a >> shamt;           alu_wr = 1'b1; end
            OP_SRA: begin alu_res = $signed(op_a) >>> shamt; alu_wr = 1'b1; end
            OP_SLT: begin
                alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
                alu_wr  = 1'b1;
            end
            OP_MOV: begin alu_res = op_b;                    alu_wr = 1'b1; end
            default: begin end
        endcase
    end

`ifdef EXEC_MUL_EN
    state_t      state_q, state_d;
    logic [3:0]  mul_dest_q, mul_dest_d;
    logic        mul_start;
    logic        mul_done;
    logic [31:0] mul_res;

    assign mul_start = accept_vld && (alu_op == OP_MUL);

    mul_seq u_mul_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .op_a   (op_a),
        .op_b   (op_b),
        .done   (mul_done),
        .result (mul_res)
    );

    always_comb begin
        state_d    = state_q;
        mul_dest_d = mul_start ? dest : mul_dest_q;
        case (state_q)
            IDLE:    if (mul_start) state_d = MUL;
            MUL:     if (mul_done)  state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mul_dest_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            mul_dest_q <= mul_dest_d;
        end
    end

    assign busy = (state_q != IDLE);
`else
    assign busy = 1'b0;
`endif

    assign ready = !busy;

    always_comb begin
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        flags_d   = flags_q;
        if (accept_vld && alu_wr) begin
            wb_en_d   = 1'b1;
            wb_addr_d = dest;
            wb_data_d = alu_res;
        end
        if (accept_vld && alu_upd) begin
            flags_d[FLAG_Z] = (alu_res == 32'd0);
            flags_d[FLAG_N] = alu_res[31];
            flags_d[FLAG_C] = alu_c;
            flags_d[FLAG_V] = alu_v;
        end
`ifdef EXEC_MUL_EN
        // Final iteration edge: latch product so the strobe lands in the WB cycle
        if (mul_done) begin
            wb_en_d         = 1'b1;
            wb_addr_d       = mul_dest_q;
            wb_data_d       = mul_res;
            flags_d[FLAG_Z] = (mul_res == 32'd0);
            flags_d[FLAG_N] = mul_res[31];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= 4'd0;
            wb_data_q <= 32'd0;
            flags_q   <= 4'd0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            flags_q   <= flags_d;
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign flags   = flags_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed vectors plus randomized ops against a behavioural model.
// Multiply scenarios are selected by EXEC_MUL_EN, matching the DUT build.
module tb_exec_unit;

    localparam logic [3:0] T_ADD = 4'd0, T_SUB = 4'd1, T_OR = 4'd3, T_SLL = 4'd5, T_SRA = 4'd7;
    localparam logic [3:0] T_SLT = 4'd8, T_MOV = 4'd9, T_MUL = 4'd10, T_CMP = 4'd11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [3:0]  dest = 4'd0;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected architectural state: last writeback address/data and {Z,N,C,V}
    logic [31:0] m_data  = 32'd0;
    logic [3:0]  m_addr  = 4'd0;
    logic [3:0]  m_flags = 4'd0;

    exec_unit dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .ready    (ready),
        .alu_op   (alu_op),
        .op_a     (op_a),
        .op_b     (op_b),
        .dest     (dest),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .busy     (busy),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic computed on wide integers, then reduced to the architectural rules
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] d, output logic exp_wb);
        int              sa, sb, sh;
        longint          ls;
        longint unsigned us;
        logic [31:0]     r;
        logic            wr, upd, c, v;
        sa = a; sb = b; sh = int'(b % 32);
        wr = 1'b1; upd = 1'b0; c = 1'b0; v = 1'b0; r = 32'd0; ls = 0; us = 0;
        case (op)
            4'd0: begin
                us = longint'(a) + longint'(b);
                r = us[31:0]; c = (us > 64'hFFFF_FFFF);
                ls = longint'(sa) + longint'(sb); upd = 1'b1;
            end
            4'd1, 4'd11: begin
                r = a - b; c = (a < b);
                ls = longint'(sa) - longint'(sb); upd = 1'b1; wr = (op == 4'd1);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            4'd7: r = sa >>> sh;
            4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: r = b;
            default: wr = 1'b0;
        endcase
        if (upd) v = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
        if (wr) begin m_data = r; m_addr = d; end
        if (upd) m_flags = {(r == 32'd0), r[31], c, v};
        exp_wb = wr;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] d, output logic exp_wb);
        valid_in = 1'b1; alu_op = op; op_a = a; op_b = b; dest = d;
        step();
        valid_in = 1'b0;
        model_op(op, a, b, d, exp_wb);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        logic e;
        logic saw_wb;
        rst = 1'b1;
        step(); step();
        n_checks++; if ({wb_en, wb_addr, wb_data} !== 37'd0) $display("FAIL reset_wb got %b/%h/%h want 0/0/0", wb_en, wb_addr, wb_data); else n_pass++;
        n_checks++; if ({busy, ready, flags} !== 6'b010000) $display("FAIL reset_ctl busy=%b ready=%b flags=%b want 0/1/0000", busy, ready, flags); else n_pass++;
        rst = 1'b0;
        issue(T_ADD, 32'hFFFF_FFFF, 32'd2, 4'd7, e);
`ifdef EXEC_MUL_EN
        valid_in = 1'b1; alu_op = T_MUL; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF1; dest = 4'd9;
        step();
        valid_in = 1'b0;
        repeat (10) step();
        n_checks++; if (busy !== 1'b1) $display("FAIL reset_mul_inflight busy=%b want 1", busy); else n_pass++;
`endif
        rst = 1'b1; valid_in = 1'b1; alu_op = T_ADD; op_a = 32'd5; op_b = 32'd6; dest = 4'd4;
        step();
        rst = 1'b0; valid_in = 1'b0;
        n_checks++; if ({wb_en, wb_addr, wb_data} !== 37'd0) $display("FAIL reset_abort_wb got %b/%h/%h want 0/0/0", wb_en, wb_addr, wb_data); else n_pass++;
        n_checks++; if ({busy, ready, flags} !== 6'b010000) $display("FAIL reset_abort_ctl busy=%b ready=%b flags=%b want 0/1/0000", busy, ready, flags); else n_pass++;
        saw_wb = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (wb_en !== 1'b0) saw_wb = 1'b1;
        end
        n_checks++; if (saw_wb !== 1'b0) $display("FAIL reset_no_wb saw wb_en=1 want none in 40 cycles"); else n_pass++;
        m_data = 32'd0; m_addr = 4'd0; m_flags = 4'd0;
    endtask

    task automatic test_flags();
        logic e;
        issue(T_ADD, 32'h7FFF_FFFF, 32'd1, 4'd3, e);
        n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 4'd3, 32'h8000_0000}) $display("FAIL add_wb got %b/%h/%h want 1/3/80000000", wb_en, wb_addr, wb_data); else n_pass++;
        n_checks++; if (flags !== 4'b0101) $display("FAIL add_flags got %b want 0101", flags); else n_pass++;
        step();
        n_checks++; if (wb_en !== 1'b0) $display("FAIL add_single_pulse wb_en=%b want 0", wb_en); else n_pass++;
        issue(T_SUB, 32'd5, 32'd7, 4'd2, e);
        n_checks++; if ({wb_en, wb_data} !== {1'b1, 32'hFFFF_FFFE}) $display("FAIL sub_wb got %b/%h want 1/fffffffe", wb_en, wb_data); else n_pass++;
        n_checks++; if (flags !== 4'b0110) $display("FAIL sub_flags got %b want 0110", flags); else n_pass++;
        issue(T_CMP, 32'd9, 32'd9, 4'd8, e);
        n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b0, 4'd2, 32'hFFFF_FFFE}) $display("FAIL cmp_no_wb got %b/%h/%h want 0/2/fffffffe", wb_en, wb_addr, wb_data); else n_pass++;
        n_checks++; if (flags !== 4'b1000) $display("FAIL cmp_flags got %b want 1000", flags); else n_pass++;
    endtask

    task automatic test_shifts();
        logic e;
        issue(T_SRA, 32'h8000_0000, 32'h21, 4'd1, e);
        n_checks++; if (wb_data !== 32'hC000_0000) $display("FAIL sra got %h want c0000000", wb_data); else n_pass++;
        n_checks++; if (flags !== 4'b1000) $display("FAIL sra_flags_held got %b want 1000", flags); else n_pass++;
        issue(T_SLL, 32'd1, 32'd31, 4'd1, e);
        n_checks++; if (wb_data !== 32'h8000_0000) $display("FAIL sll got %h want 80000000", wb_data); else n_pass++;
        issue(T_SLT, 32'hFFFF_FFFF, 32'd1, 4'd6, e);
        n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 4'd6, 32'd1}) $display("FAIL slt got %b/%h/%h want 1/6/1", wb_en, wb_addr, wb_data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic e;
        valid_in = 1'b1; alu_op = T_ADD; op_a = 32'd10; op_b = 32'd20; dest = 4'd1;
        step(); model_op(T_ADD, 32'd10, 32'd20, 4'd1, e);
        n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 4'd1, 32'd30}) $display("FAIL b2b_add got %b/%h/%h want 1/1/1e", wb_en, wb_addr, wb_data); else n_pass++;
        alu_op = T_OR; op_a = 32'hF0; op_b = 32'h0F; dest = 4'd2;
        step(); model_op(T_OR, 32'hF0, 32'h0F, 4'd2, e);
        n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 4'd2, 32'hFF}) $display("FAIL b2b_or got %b/%h/%h want 1/2/ff", wb_en, wb_addr, wb_data); else n_pass++;
        alu_op = T_MOV; op_a = 32'hDEAD; op_b = 32'h1234; dest = 4'd3;
        step(); model_op(T_MOV, 32'hDEAD, 32'h1234, 4'd3, e);
        n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b1, 4'd3, 32'h1234}) $display("FAIL b2b_mov got %b/%h/%h want 1/3/1234", wb_en, wb_addr, wb_data); else n_pass++;
        valid_in = 1'b0;
        step();
        n_checks++; if ({wb_en, wb_addr, wb_data, flags} !== {1'b0, m_addr, m_data, m_flags}) $display("FAIL b2b_idle got %b/%h/%h/%b want 0/%h/%h/%b", wb_en, wb_addr, wb_data, flags, m_addr, m_data, m_flags); else n_pass++;
    endtask

    task automatic test_random();
        logic        v, e;
        logic [3:0]  op, d;
        logic [31:0] a, b;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 15));
`ifdef EXEC_MUL_EN
            if (op == T_MUL) op = T_MOV;
`endif
            a = rnd_operand(); b = rnd_operand(); d = 4'($urandom);
            valid_in = v; alu_op = op; op_a = a; op_b = b; dest = d;
            step();
            e = 1'b0;
            if (v) model_op(op, a, b, d, e);
            n_checks++;
            if ({wb_en, wb_addr, wb_data, flags, ready, busy} !== {e, m_addr, m_data, m_flags, 1'b1, 1'b0})
                $display("FAIL random[%0d] op=%0d a=%h b=%h got wb=%b/%h/%h fl=%b rdy=%b busy=%b want %b/%h/%h fl=%b rdy=1 busy=0",
                         i, op, a, b, wb_en, wb_addr, wb_data, flags, ready, busy, e, m_addr, m_data, m_flags);
            else n_pass++;
        end
        valid_in = 1'b0;
    endtask

`ifdef EXEC_MUL_EN
    task automatic test_mul();
        logic            e;
        logic [31:0]     a, b, prod;
        longint unsigned p;
        int              cyc;
        valid_in = 1'b1; alu_op = T_MUL; op_a = 32'h0001_0000; op_b = 32'h0001_0001; dest = 4'd6;
        step();
        // Hold a different op on the inputs for the whole multiply; it must wait and not disturb it
        alu_op = T_ADD; op_a = 32'd1; op_b = 32'd2; dest = 4'd5;
        for (int k = 1; k <= 33; k++) begin
            n_checks++;
            if ({busy, ready, wb_en} !== {1'b1, 1'b0, (k == 33)})
                $display("FAIL mul_timing cycle N+%0d busy=%b ready=%b wb_en=%b want 1/0/%b", k, busy, ready, wb_en, (k == 33));
            else n_pass++;
            if (k == 33) begin
                m_flags[3] = 1'b0; m_flags[2] = 1'b0; m_data = 32'h0001_0000; m_addr = 4'd6;
                n_checks++; if ({wb_addr, wb_data, flags} !== {m_addr, m_data, m_flags}) $display("FAIL mul_result got %h/%h/%b want %h/%h/%b", wb_addr, wb_data, flags, m_addr, m_data, m_flags); else n_pass++;
            end else begin
                step();
            end
        end
        step();
        n_checks++; if ({busy, ready, wb_en} !== 3'b010) $display("FAIL mul_release busy=%b ready=%b wb_en=%b want 0/1/0", busy, ready, wb_en); else n_pass++;
        step();
        valid_in = 1'b0;
        model_op(T_ADD, 32'd1, 32'd2, 4'd5, e);
        n_checks++; if ({wb_en, wb_addr, wb_data, flags} !== {1'b1, m_addr, m_data, m_flags}) $display("FAIL mul_held_op got %b/%h/%h/%b want 1/%h/%h/%b", wb_en, wb_addr, wb_data, flags, m_addr, m_data, m_flags); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            a = rnd_operand(); b = rnd_operand();
            valid_in = 1'b1; alu_op = T_MUL; op_a = a; op_b = b; dest = 4'(i + 8);
            step();
            valid_in = 1'b0; op_a = $urandom; op_b = $urandom; dest = 4'($urandom);
            cyc = 1;
            while (wb_en !== 1'b1 && cyc < 40) begin step(); cyc++; end
            p = longint'(a) * longint'(b);
            prod = p[31:0];
            m_data = prod; m_addr = 4'(i + 8);
            m_flags[3] = (prod == 32'd0); m_flags[2] = prod[31];
            n_checks++; if (cyc !== 33) $display("FAIL mul_rand[%0d]_latency got %0d want 33", i, cyc); else n_pass++;
            n_checks++; if ({wb_addr, wb_data, flags} !== {m_addr, m_data, m_flags}) $display("FAIL mul_rand[%0d] a=%h b=%h got %h/%h/%b want %h/%h/%b", i, a, b, wb_addr, wb_data, flags, m_addr, m_data, m_flags); else n_pass++;
            step();
        end
    endtask
`else
    task automatic test_mul_disabled();
        logic saw_busy;
        logic e;
        issue(T_ADD, 32'h8000_0000, 32'h8000_0000, 4'd4, e);
        valid_in = 1'b1; alu_op = T_MUL; op_a = 32'd3; op_b = 32'd4; dest = 4'd12;
        step();
        valid_in = 1'b0;
        n_checks++; if ({wb_en, wb_addr, wb_data} !== {1'b0, m_addr, m_data}) $display("FAIL mul_off_wb got %b/%h/%h want 0/%h/%h", wb_en, wb_addr, wb_data, m_addr, m_data); else n_pass++;
        n_checks++; if (flags !== m_flags) $display("FAIL mul_off_flags got %b want %b", flags, m_flags); else n_pass++;
        saw_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b0 || ready !== 1'b1 || wb_en !== 1'b0) saw_busy = 1'b1;
            step();
        end
        n_checks++; if (saw_busy !== 1'b0) $display("FAIL mul_off_idle saw busy/ready/wb_en activity want none"); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_flags();
        test_shifts();
        test_back_to_back();
        test_random();
`ifdef EXEC_MUL_EN
        test_mul();
`else
        test_mul_disabled();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
